icache_refill_ctrl: RTL and testbench

//  Sequences instruction-side misses from the IT/IC fetch stages onto one AXI-style read channel.

---
 rtl/icache_refill_ctrl_if.sv | 21 ++
 rtl/icache_refill_ctrl.sv | 153 +++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Read channel between the icache refill controller and the instruction-side AXI-style bus.
// The master side issues the request and the slave side returns the data beats.
interface icache_refill_ctrl_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_addr_ok;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic        rd_last;

    modport master (
        output rd_req, rd_addr, rd_len,
        input  rd_addr_ok, rd_data_valid, rd_data, rd_last
    );

    modport slave (
        input  rd_req, rd_addr, rd_len,
        output rd_addr_ok, rd_data_valid, rd_data, rd_last
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-side miss sequencer: line refill by burst for cached misses, single beat for
// uncached fetches, with stall request and flush/branch kill of the pending response.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 20,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int IDX_W     = 32 - TAG_W - OFF_W - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 br_e,
    input  logic                 miss_valid,
    input  logic                 miss_uncached,
    input  logic [31:0]          miss_addr,
    output logic                 stallreq,
    icache_refill_ctrl_if.master bus,
    output logic                 fill_we,
    output logic [IDX_W-1:0]     fill_index,
    output logic [OFF_W-1:0]     fill_word,
    output logic [31:0]          fill_data,
    output logic                 tag_we,
    output logic [TAG_W-1:0]     fill_tag,
    output logic                 resp_valid,
    output logic [31:0]          resp_inst
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             uncached_q, uncached_d;
    logic             kill_q, kill_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [31:0]      resp_inst_q, resp_inst_d;

    logic             abort;
    logic             accept;
    logic             beat;
    logic             hit_word;
    logic [31:0]      line_addr;

    assign abort     = flush | br_e;
    assign accept    = (state_q == S_IDLE) && miss_valid && !abort;
    assign beat      = (state_q == S_RECV) && bus.rd_data_valid;
    assign line_addr = {addr_q[31:OFF_W+2], {(OFF_W + 2){1'b0}}};
    assign hit_word  = uncached_q ? (cnt_q == '0) : (cnt_q == addr_q[OFF_W+1:2]);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        uncached_d  = uncached_q;
        kill_d      = kill_q;
        cnt_d       = cnt_q;
        resp_inst_d = resp_inst_q;
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    addr_d     = miss_addr;
                    uncached_d = miss_uncached;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) kill_d = 1'b1;
                if (bus.rd_addr_ok) begin
                    cnt_d   = '0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (abort) kill_d = 1'b1;
                if (beat) begin
                    if (hit_word) resp_inst_d = bus.rd_data;
                    if (cnt_q != OFF_W'(LINE_WORDS - 1)) cnt_d = cnt_q + 1'b1;
                    // A redirect on the final beat already makes the response stale.
                    if (bus.rd_last) begin
                        if (kill_q || abort) begin
                            kill_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            uncached_q  <= 1'b0;
            kill_q      <= 1'b0;
            cnt_q       <= '0;
            resp_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            uncached_q  <= uncached_d;
            kill_q      <= kill_d;
            cnt_q       <= cnt_d;
            resp_inst_q <= resp_inst_d;
        end
    end

    // Outputs are forced quiet while rst is high so the pipeline sees no stall or write.
    always_comb begin
        stallreq    = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.rd_len  = '0;
        fill_we     = 1'b0;
        fill_index  = '0;
        fill_word   = '0;
        fill_data   = '0;
        tag_we      = 1'b0;
        fill_tag    = '0;
        resp_valid  = 1'b0;
        if (!rst) begin
            stallreq   = (state_q == S_REQ) || (state_q == S_RECV) || accept;
            bus.rd_req = (state_q == S_REQ);
            if (state_q == S_REQ) begin
                bus.rd_addr = uncached_q ? addr_q : line_addr;
                bus.rd_len  = uncached_q ? 8'd0 : 8'(LINE_WORDS - 1);
            end
            fill_we = beat && !uncached_q;
            tag_we  = fill_we && bus.rd_last;
            if (fill_we) begin
                fill_word  = cnt_q;
                fill_data  = bus.rd_data;
                fill_index = addr_q[31-TAG_W:OFF_W+2];
                fill_tag   = addr_q[31:32-TAG_W];
            end
            resp_valid = (state_q == S_DONE) && !abort;
        end
    end

    assign resp_inst = resp_inst_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed transactions with literal expectations, then random
// misses, redirects, resets and bus timing checked every cycle against a transaction-level model.
module tb_icache_refill_ctrl;
    localparam int LW    = 8;
    localparam int TAG_W = 20;
    localparam int OFF_W = 3;
    localparam int IDX_W = 32 - TAG_W - OFF_W - 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             br_e = 1'b0;
    logic             miss_valid = 1'b0;
    logic             miss_uncached = 1'b0;
    logic [31:0]      miss_addr = '0;
    logic             stallreq;
    logic             fill_we;
    logic [IDX_W-1:0] fill_index;
    logic [OFF_W-1:0] fill_word;
    logic [31:0]      fill_data;
    logic             tag_we;
    logic [TAG_W-1:0] fill_tag;
    logic             resp_valid;
    logic [31:0]      resp_inst;

    icache_refill_ctrl_if bus_if ();

    icache_refill_ctrl #(.LINE_WORDS(LW), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .br_e         (br_e),
        .miss_valid   (miss_valid),
        .miss_uncached(miss_uncached),
        .miss_addr    (miss_addr),
        .stallreq     (stallreq),
        .bus          (bus_if),
        .fill_we      (fill_we),
        .fill_index   (fill_index),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .tag_we       (tag_we),
        .fill_tag     (fill_tag),
        .resp_valid   (resp_valid),
        .resp_inst    (resp_inst)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Bus slave configuration; directed tests pin the timing and data pattern.
    int          cfg_wait_fixed = 0;
    int          cfg_wait_max = 0;
    int          cfg_valid_pct = 100;
    bit          cfg_short = 1'b0;
    bit          cfg_junk = 1'b0;
    bit          cfg_base_en = 1'b1;
    logic [31:0] cfg_base = '0;

    initial begin
        int sl_state;
        int sl_wait;
        int sl_beats;
        int sl_i;
        sl_state = 0; sl_wait = 0; sl_beats = 0; sl_i = 0;
        bus_if.rd_addr_ok = 1'b0; bus_if.rd_data_valid = 1'b0;
        bus_if.rd_data = '0; bus_if.rd_last = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus_if.rd_addr_ok    = 1'b0;
            bus_if.rd_data_valid = 1'b0;
            bus_if.rd_last       = 1'b0;
            bus_if.rd_data       = $urandom;
            if (rst) begin
                sl_state = 0;
            end else begin
                if (sl_state == 0 && bus_if.rd_req) begin
                    sl_state = 1;
                    sl_wait  = (cfg_wait_fixed >= 0) ? cfg_wait_fixed : int'($urandom_range(0, cfg_wait_max));
                    sl_beats = int'(bus_if.rd_len) + 1;
                    if (cfg_short && sl_beats > 1 && $urandom_range(0, 5) == 0)
                        sl_beats = int'($urandom_range(1, sl_beats - 1));
                end
                if (sl_state == 1) begin
                    if (sl_wait == 0) begin
                        bus_if.rd_addr_ok = 1'b1;
                        sl_state = 2;
                        sl_i = 0;
                    end else begin
                        sl_wait--;
                    end
                end else if (sl_state == 2) begin
                    if (int'($urandom_range(0, 99)) < cfg_valid_pct) begin
                        bus_if.rd_data_valid = 1'b1;
                        if (cfg_base_en) bus_if.rd_data = cfg_base + 32'(sl_i);
                        bus_if.rd_last = (sl_i == sl_beats - 1);
                        sl_i++;
                        if (bus_if.rd_last) sl_state = 0;
                    end
                end else if (cfg_junk && $urandom_range(0, 7) == 0) begin
                    bus_if.rd_data_valid = 1'b1;
                    bus_if.rd_last = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Transaction-level model: one outstanding miss, its grant, beats seen and pending response.
    bit          m_txn = 1'b0;
    bit          m_granted = 1'b0;
    bit          m_killed = 1'b0;
    bit          m_unc = 1'b0;
    bit          m_done = 1'b0;
    bit          m_after_rst = 1'b0;
    int          m_beats = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_resp = '0;

    always @(negedge clk) begin
        bit abort, e_stall, e_req, beat, e_fill, e_tag, e_resp;
        int widx;
        abort = flush || br_e;
        if (rst) begin
            checkOutput("rst_stallreq", 32'(stallreq), 32'd0);
            checkOutput("rst_rd_req", 32'(bus_if.rd_req), 32'd0);
            checkOutput("rst_fill_we", 32'(fill_we), 32'd0);
            checkOutput("rst_tag_we", 32'(tag_we), 32'd0);
            checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
            m_txn = 1'b0; m_done = 1'b0; m_resp = '0; m_after_rst = 1'b1;
        end else begin
            e_stall = m_txn || (!m_done && miss_valid && !abort);
            e_req   = m_txn && !m_granted;
            beat    = m_txn && m_granted && bus_if.rd_data_valid;
            e_fill  = beat && !m_unc;
            e_tag   = e_fill && bus_if.rd_last;
            e_resp  = m_done && !abort;
            widx    = (m_beats > LW - 1) ? LW - 1 : m_beats;
            checkOutput("stallreq", 32'(stallreq), 32'(e_stall));
            checkOutput("rd_req", 32'(bus_if.rd_req), 32'(e_req));
            checkOutput("fill_we", 32'(fill_we), 32'(e_fill));
            checkOutput("tag_we", 32'(tag_we), 32'(e_tag));
            checkOutput("resp_valid", 32'(resp_valid), 32'(e_resp));
            if (m_after_rst) checkOutput("resp_inst_after_rst", resp_inst, 32'd0);
            m_after_rst = 1'b0;
            if (e_req) begin
                checkOutput("rd_addr", bus_if.rd_addr,
                            m_unc ? m_addr : (m_addr & ~32'(LW * 4 - 1)));
                checkOutput("rd_len", 32'(bus_if.rd_len), m_unc ? 32'd0 : 32'(LW - 1));
            end
            if (e_fill) begin
                checkOutput("fill_word", 32'(fill_word), 32'(widx));
                checkOutput("fill_data", fill_data, bus_if.rd_data);
                checkOutput("fill_index", 32'(fill_index), (m_addr >> (OFF_W + 2)) % (1 << IDX_W));
                if (e_tag) checkOutput("fill_tag", 32'(fill_tag), m_addr >> (32 - TAG_W));
            end
            if (e_resp) checkOutput("resp_inst", resp_inst, m_resp);

            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_txn) begin
                if (miss_valid && !abort) begin
                    m_txn = 1'b1; m_granted = 1'b0; m_killed = 1'b0; m_beats = 0;
                    m_addr = miss_addr; m_unc = miss_uncached;
                end
            end else begin
                if (abort) m_killed = 1'b1;
                if (!m_granted) begin
                    m_granted = bus_if.rd_addr_ok;
                end else if (beat) begin
                    if (widx == (m_unc ? 0 : int'((m_addr >> 2) % LW))) m_resp = bus_if.rd_data;
                    m_beats++;
                    if (bus_if.rd_last) begin
                        m_txn  = 1'b0;
                        m_done = !m_killed;
                    end
                end
            end
        end
    end

    // One directed miss observed for 25 cycles; kind 1/2/3 pulses flush/br_e/rst at cycle ev_cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic unc, input int ev_cycle,
                                 input int kind, output int n_req, output int n_fill,
                                 output int n_tag, output int n_resp, output int n_stall,
                                 output int n_req_nostall, output logic [31:0] req_addr,
                                 output logic [31:0] req_len, output logic [31:0] tag_val,
                                 output logic [31:0] tag_word, output logic [31:0] resp_word);
        n_req = 0; n_fill = 0; n_tag = 0; n_resp = 0; n_stall = 0; n_req_nostall = 0;
        req_addr = '1; req_len = '1; tag_val = '1; tag_word = '1; resp_word = '1;
        @(posedge clk);
        #1;
        miss_valid = 1'b1; miss_uncached = unc; miss_addr = addr;
        for (int k = 0; k < 25; k++) begin
            flush = (ev_cycle == k) && (kind == 1);
            br_e  = (ev_cycle == k) && (kind == 2);
            rst   = (ev_cycle == k) && (kind == 3);
            @(negedge clk);
            if (bus_if.rd_req) begin
                if (n_req == 0) begin
                    req_addr = bus_if.rd_addr;
                    req_len  = 32'(bus_if.rd_len);
                end
                n_req++;
                if (!stallreq) n_req_nostall++;
            end
            if (stallreq) n_stall++;
            if (fill_we) n_fill++;
            if (tag_we) begin
                n_tag++;
                tag_val  = 32'(fill_tag);
                tag_word = 32'(fill_word);
            end
            if (resp_valid) begin
                n_resp++;
                resp_word = resp_inst;
            end
            @(posedge clk);
            #1;
            miss_valid = 1'b0;
        end
        flush = 1'b0; br_e = 1'b0; rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_req, n_fill, n_tag, n_resp, n_stall, n_nostall;
        logic [31:0] r_addr, r_len, t_val, t_word, r_word;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        cfg_base = 32'hA0;
        applyStimulus(32'h1FC0_0014, 1'b0, -1, 0, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T1_rd_addr", r_addr, 32'h1FC0_0000);
        checkOutput("T1_rd_len", r_len, 32'd7);
        checkOutput("T1_req_cycles", 32'(n_req), 32'd1);
        checkOutput("T1_fills", 32'(n_fill), 32'd8);
        checkOutput("T1_tags", 32'(n_tag), 32'd1);
        checkOutput("T1_tag", t_val, 32'h1FC00);
        checkOutput("T1_tag_word", t_word, 32'd7);
        checkOutput("T1_resps", 32'(n_resp), 32'd1);
        checkOutput("T1_resp_inst", r_word, 32'hA5);
        checkOutput("T1_stall_cycles", 32'(n_stall), 32'd10);

        cfg_base = 32'h3C1A_8000;
        applyStimulus(32'hBFC0_0380, 1'b1, -1, 0, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T2_rd_addr", r_addr, 32'hBFC0_0380);
        checkOutput("T2_rd_len", r_len, 32'd0);
        checkOutput("T2_fills", 32'(n_fill + n_tag), 32'd0);
        checkOutput("T2_resps", 32'(n_resp), 32'd1);
        checkOutput("T2_resp_inst", r_word, 32'h3C1A_8000);
        checkOutput("T2_stall_cycles", 32'(n_stall), 32'd3);

        cfg_base = 32'h100;
        cfg_wait_fixed = 5;
        applyStimulus(32'h0040_1238, 1'b0, -1, 0, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T3_req_cycles", 32'(n_req), 32'd6);
        checkOutput("T3_req_without_stall", 32'(n_nostall), 32'd0);
        checkOutput("T3_rd_addr", r_addr, 32'h0040_1220);
        checkOutput("T3_resp_inst", r_word, 32'h106);

        cfg_base = 32'hA0;
        cfg_wait_fixed = 0;
        applyStimulus(32'h1FC0_0014, 1'b0, 5, 2, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T4_fills", 32'(n_fill), 32'd8);
        checkOutput("T4_tags", 32'(n_tag), 32'd1);
        checkOutput("T4_resps", 32'(n_resp), 32'd0);

        cfg_base = 32'h3C1A_8000;
        cfg_wait_fixed = 2;
        applyStimulus(32'hBFC0_0380, 1'b1, 1, 1, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T5_req_cycles", 32'(n_req), 32'd3);
        checkOutput("T5_resps", 32'(n_resp), 32'd0);
        checkOutput("T5_stall_cycles", 32'(n_stall), 32'd5);
        cfg_wait_fixed = 0;
        applyStimulus(32'hBFC0_0380, 1'b1, -1, 0, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T5_next_resps", 32'(n_resp), 32'd1);

        cfg_base = 32'hA0;
        applyStimulus(32'h1FC0_0014, 1'b0, 4, 3, n_req, n_fill, n_tag, n_resp, n_stall,
                      n_nostall, r_addr, r_len, t_val, t_word, r_word);
        checkOutput("T6_fills", 32'(n_fill), 32'd2);
        checkOutput("T6_tags", 32'(n_tag), 32'd0);
        checkOutput("T6_resps", 32'(n_resp), 32'd0);
        checkOutput("T6_stall_cycles", 32'(n_stall), 32'd4);

        cfg_wait_fixed = -1;
        cfg_wait_max = 6;
        cfg_valid_pct = 70;
        cfg_short = 1'b1;
        cfg_junk = 1'b1;
        cfg_base_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst           = ($urandom_range(0, 249) == 0);
            miss_valid    = ($urandom_range(0, 2) == 0);
            miss_uncached = ($urandom_range(0, 3) == 0);
            miss_addr     = $urandom;
            flush         = ($urandom_range(0, 24) == 0);
            br_e          = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; miss_valid = 1'b0; flush = 1'b0; br_e = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
